// File: rtl/return_stack_pkg.sv
// rtl/return_stack_pkg.sv - shared defaults and operation decode for the return-address stack
//
// Purpose: default PC width and return-stack depth for the MUSA core, plus the
// per-edge operation type and the priority decode used by return_stack.
// Ports: none (package).
package return_stack_pkg;

  localparam int MUSA_PC_WIDTH  = 18;
  localparam int MUSA_RAS_DEPTH = 16;

  // The single operation a given clock edge performs, after priority resolution.
  typedef enum logic [2:0] {
    OP_IDLE    = 3'd0,
    OP_FLUSH   = 3'd1,
    OP_REPLACE = 3'd2,
    OP_PUSH    = 3'd3,
    OP_POP     = 3'd4
  } stack_op_e;

  // flush > push&pop > push > pop > idle. Push+pop on an empty stack has no
  // top to replace, so it degrades to a plain push (and never flags underflow).
  function automatic stack_op_e decode_op(input logic flush, input logic push,
                                          input logic pop, input logic empty);
    stack_op_e op;
    if (flush)                  op = OP_FLUSH;
    else if (push && pop && !empty) op = OP_REPLACE;
    else if (push)              op = OP_PUSH;
    else if (pop)               op = OP_POP;
    else                        op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - DEPTH x WIDTH storage with one sync write and one async read port
//
// Purpose: unreset register array holding the return addresses.
// Ports:
//   clk    in   1      write clock
//   we     in   1      write enable
//   waddr  in   PTR_W  write address
//   wdata  in   WIDTH  write data
//   raddr  in   PTR_W  read address
//   rdata  out  WIDTH  read data, combinational from raddr
module stack_regfile #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// rtl/return_stack.sv - clocked return-address stack with status, sticky flags and wrap mode
//
// Purpose: CALL pushes the return PC, RET pops it; top_o feeds the PC mux.
// Ports:
//   clk          in   1      clock
//   rst_n        in   1      asynchronous reset, active-low
//   push_i       in   1      push data_i
//   pop_i        in   1      pop top entry
//   flush_i      in   1      synchronous clear of stack and sticky flags
//   data_i       in   WIDTH  return PC to push
//   top_o        out  WIDTH  current top entry, 0 when empty
//   empty_o      out  1      no valid entries
//   full_o       out  1      DEPTH valid entries
//   count_o      out  CNT_W  number of valid entries
//   overflow_o   out  1      sticky: push while full
//   underflow_o  out  1      sticky: pop while empty
module return_stack
  import return_stack_pkg::*;
#(
  parameter int WIDTH     = MUSA_PC_WIDTH,
  parameter int DEPTH     = MUSA_RAS_DEPTH,
  parameter bit WRAP_MODE = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [PTR_W-1:0] ptr;       // next free slot
  logic [PTR_W-1:0] top_idx;   // slot of the current top
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             empty;
  logic             full;
  stack_op_e        op;

  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [WIDTH-1:0] rdata;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign top_idx = ptr - PTR_W'(1);
  assign op      = decode_op(flush_i, push_i, pop_i, empty);

  // A push while full only writes in wrap mode, where it lands on the oldest
  // slot (ptr == oldest once the ring is full).
  always_comb begin
    we    = 1'b0;
    waddr = ptr;
    case (op)
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = top_idx;
      end
      OP_PUSH:    we = !full || WRAP_MODE;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (op)
        OP_FLUSH: begin
          ptr       <= '0;
          count     <= '0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        OP_PUSH: begin
          if (!full) begin
            ptr   <= ptr + PTR_W'(1);
            count <= count + CNT_W'(1);
          end else begin
            overflow <= 1'b1;
            if (WRAP_MODE) ptr <= ptr + PTR_W'(1);
          end
        end
        OP_POP: begin
          if (!empty) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
          end else begin
            underflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_i),
    .raddr (top_idx),
    .rdata (rdata)
  );

  // Storage is not reset, so the top must be masked while empty.
  assign top_o       = empty ? '0 : rdata;
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count;
  assign overflow_o  = overflow;
  assign underflow_o = underflow;

endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - directed bench for return_stack in drop and wrap modes
module tb_return_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        flush = 1'b0;
  logic [17:0] data = '0;

  logic [17:0] top0, top1;
  logic        empty0, empty1, full0, full1, of0, of1, uf0, uf1;
  logic [2:0]  cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  return_stack #(.WIDTH(18), .DEPTH(4), .WRAP_MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .flush_i(flush),
    .data_i(data), .top_o(top0), .empty_o(empty0), .full_o(full0),
    .count_o(cnt0), .overflow_o(of0), .underflow_o(uf0)
  );

  return_stack #(.WIDTH(18), .DEPTH(4), .WRAP_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .flush_i(flush),
    .data_i(data), .top_o(top1), .empty_o(empty1), .full_o(full1),
    .count_o(cnt1), .overflow_o(of1), .underflow_o(uf1)
  );

  // Model: each stack is a queue, oldest at the front, top at the back.
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  bit m_of0, m_uf0, m_of1, m_uf1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_of0 = 0; m_uf0 = 0; m_of1 = 0; m_uf1 = 0;
    end else if (flush) begin
      q0.delete(); q1.delete();
      m_of0 = 0; m_uf0 = 0; m_of1 = 0; m_uf1 = 0;
    end else if (push && pop && q0.size() > 0) begin
      q0[q0.size()-1] = data;
      q1[q1.size()-1] = data;
    end else if (push) begin
      if (q0.size() < 4) q0.push_back(data);
      else m_of0 = 1;
      if (q1.size() < 4) q1.push_back(data);
      else begin
        m_of1 = 1;
        void'(q1.pop_front());
        q1.push_back(data);
      end
    end else if (pop) begin
      if (q0.size() > 0) void'(q0.pop_back()); else m_uf0 = 1;
      if (q1.size() > 0) void'(q1.pop_back()); else m_uf1 = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("d0.count", 32'(cnt0), q0.size());
    chk("d0.top", 32'(top0), (q0.size() != 0) ? 32'(q0[q0.size()-1]) : 32'h0);
    chk("d0.empty", 32'(empty0), 32'(q0.size() == 0));
    chk("d0.full", 32'(full0), 32'(q0.size() == 4));
    chk("d0.overflow", 32'(of0), 32'(m_of0));
    chk("d0.underflow", 32'(uf0), 32'(m_uf0));
    chk("d1.count", 32'(cnt1), q1.size());
    chk("d1.top", 32'(top1), (q1.size() != 0) ? 32'(q1[q1.size()-1]) : 32'h0);
    chk("d1.empty", 32'(empty1), 32'(q1.size() == 0));
    chk("d1.full", 32'(full1), 32'(q1.size() == 4));
    chk("d1.overflow", 32'(of1), 32'(m_of1));
    chk("d1.underflow", 32'(uf1), 32'(m_uf1));
  end

  task automatic op(input logic p, input logic q, input logic f, input logic [17:0] d);
    push = p; pop = q; flush = f; data = d;
    @(posedge clk);
    #2;
    push = 0; pop = 0; flush = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("lit.reset_count", 32'(cnt0), 32'd0);
    chk("lit.reset_empty", 32'(empty0), 32'd1);
    chk("lit.reset_top", 32'(top0), 32'd0);
    chk("lit.reset_flags", {30'd0, of0, uf0}, 32'd0);
    rst_n = 1'b1;

    // basic LIFO
    op(1, 0, 0, 18'h00010);
    op(1, 0, 0, 18'h00020);
    op(1, 0, 0, 18'h00030);
    chk("lit.count3", 32'(cnt0), 32'd3);
    chk("lit.top30", 32'(top0), 32'h30);
    op(0, 1, 0, '0);
    chk("lit.pop_top20", 32'(top0), 32'h20);
    op(0, 1, 0, '0);
    chk("lit.pop_top10", 32'(top0), 32'h10);
    op(0, 1, 0, '0);
    chk("lit.pop_top0", 32'(top0), 32'h0);
    chk("lit.pop_empty", 32'(empty0), 32'd1);

    // overfill: drop vs wrap
    op(0, 0, 1, '0);
    for (int i = 1; i <= 5; i++) op(1, 0, 0, 18'(i));
    chk("lit.d0_full", 32'(full0), 32'd1);
    chk("lit.d0_of", 32'(of0), 32'd1);
    chk("lit.d0_top4", 32'(top0), 32'd4);
    chk("lit.d1_count4", 32'(cnt1), 32'd4);
    chk("lit.d1_of", 32'(of1), 32'd1);
    chk("lit.d1_top5", 32'(top1), 32'd5);
    op(0, 1, 0, '0);
    chk("lit.d0_top3", 32'(top0), 32'd3);
    chk("lit.d1_top4", 32'(top1), 32'd4);
    op(0, 1, 0, '0);
    chk("lit.d0_top2", 32'(top0), 32'd2);
    chk("lit.d1_top3", 32'(top1), 32'd3);
    op(0, 1, 0, '0);
    chk("lit.d0_top1", 32'(top0), 32'd1);
    chk("lit.d1_top2", 32'(top1), 32'd2);
    op(0, 1, 0, '0);
    chk("lit.d0_drained", 32'(empty0), 32'd1);
    chk("lit.d1_drained", 32'(empty1), 32'd1);

    // underflow, push+pop on empty, flush
    op(0, 0, 1, '0);
    op(0, 1, 0, '0);
    chk("lit.uf_set", 32'(uf0), 32'd1);
    chk("lit.uf_count0", 32'(cnt0), 32'd0);
    op(1, 1, 0, 18'h3FFFF);
    chk("lit.pp_empty_count", 32'(cnt0), 32'd1);
    chk("lit.pp_empty_top", 32'(top0), 32'h3FFFF);
    chk("lit.pp_empty_uf", 32'(uf0), 32'd1);
    op(0, 0, 1, '0);
    chk("lit.flush_count", 32'(cnt0), 32'd0);
    chk("lit.flush_flags", {30'd0, of0, uf0}, 32'd0);

    // top replace, including when full
    op(1, 0, 0, 18'h00AAA);
    op(1, 1, 0, 18'h00BBB);
    chk("lit.replace_count", 32'(cnt0), 32'd1);
    chk("lit.replace_top", 32'(top0), 32'hBBB);
    for (int i = 1; i <= 3; i++) op(1, 0, 0, 18'(i));
    op(1, 1, 0, 18'h00CCC);
    chk("lit.replace_full_top", 32'(top0), 32'hCCC);
    chk("lit.replace_full_of", 32'(of0), 32'd0);
    chk("lit.replace_full_cnt", 32'(cnt0), 32'd4);
    chk("lit.replace_full_top_w", 32'(top1), 32'hCCC);
    op(0, 1, 0, '0);
    chk("lit.under_replace", 32'(top0), 32'd2);

    // asynchronous reset between edges
    op(0, 0, 1, '0);
    op(1, 0, 0, 18'h00007);
    op(1, 0, 0, 18'h00008);
    rst_n = 1'b0;
    #1;
    chk("lit.arst_count", 32'(cnt0), 32'd0);
    chk("lit.arst_empty", 32'(empty0), 32'd1);
    chk("lit.arst_top", 32'(top0), 32'd0);
    chk("lit.arst_count_w", 32'(cnt1), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    op(1, 0, 0, 18'h00009);
    chk("lit.post_rst_count", 32'(cnt0), 32'd1);
    chk("lit.post_rst_top", 32'(top0), 32'd9);

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
